dds_phase_gen: RTL and testbench
================================

// Module: dds_phase_gen
// PURPOSE
//  Direct digital synthesis source feeding the DDS[7:0] input of the waveform generator.
//  - Phase accumulator stepped by a loadable frequency tuning word (FTW).
//  - Phase mapped to an 8-bit offset-binary sample: sine (quarter-wave LUT), saw, square or triangle.
//  - 3-stage pipeline with valid and wrap flags so downstream logic can align to sample boundaries.
// PARAMETERS
//  ACC_W   16  phase accumulator width; top 8 bits form the phase index
//  LUT_AW  6   quarter-wave LUT address width (64 entries); fixed at 6 for PHASE index of 8 bits
//  OUT_W   8   sample width (offset binary, midscale = 128)
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  en         in   1       accumulator step enable; one sample produced per enabled cycle
//  ftw_load   in   1       load ftw_in into FTW register
//  ftw_in     in   ACC_W   frequency tuning word
//  phase_ofs  in   8       phase offset added to phase index (mod 256), sampled every cycle
//  mode       in   2       00 sine, 01 saw, 10 square, 11 triangle
//  dds_out    out  OUT_W   sample, registered
//  dds_valid  out  1       dds_out holds a new sample this cycle
//  wrap       out  1       accumulator overflowed on the step that produced this sample
// BEHAVIOUR
//  - Reset (sync, active-high): acc=0, ftw=0, pipeline cleared, dds_out=0, dds_valid=0, wrap=0.
//    Reset mid-operation discards in-flight samples; no valid on the cycle after rst.
//  - FTW: ftw <= ftw_in when ftw_load. If ftw_load and en coincide, that step uses the OLD ftw.
//  - S0 (accumulator): if en, {carry,acc} <= acc + ftw (mod 2^ACC_W, carry kept); else acc holds.
//    ftw=0 with en=1: acc constant, dds_valid still pulses, wrap never asserts.
//  - S1: p = acc[ACC_W-1:ACC_W-8] + phase_ofs (8-bit wrap); q = p[7:6];
//    idx = q[0] ? ~p[5:0] : p[5:0]; registered with mode, p, q, carry, en.
//  - S2: LUT read registered; LUT[i] = round(127*sin(pi/2*(i+0.5)/64)), 7-bit, LUT[0]=2, LUT[63]=127.
//  - S3 output (by mode, using S2 copies):
//    sine:     q[1] ? 128 - LUT : 128 + LUT   (range 1..255)
//    saw:      p
//    square:   p[7] ? 255 : 0
//    triangle: p[7] ? {~p[6:0],1'b0} | 1 : {p[6:0],1'b0}  (0..254 rising, 255..1 falling)
//  - Latency: en at cycle N -> dds_out/dds_valid at N+3; wrap aligned with that sample.
//  - dds_out holds last value while dds_valid=0. mode/phase_ofs changes take effect on the
//    next S1 capture; no glitch-free guarantee across a mode change.
// STRUCTURE
//  - Package dds_pkg: mode constants (DDS_SINE/SAW/SQR/TRI), LUT_DEPTH=64, MIDSCALE=8'd128.
//  - Sub-module dds_sine_qlut: synchronous 64x7 ROM (case table), addr in, data registered.
//  - Top holds FTW register, accumulator, S1/S3 registers and valid/wrap shift pipeline.
// TESTING
//  - rst held 2 cycles mid-run -> next cycle dds_out=0, dds_valid=0, wrap=0, acc restarts at 0.
//  - ftw=256, mode=sine, en=1 -> samples at phase 0,64,128,192 = 130,255,126,1; period 256.
//  - ftw=256, mode=saw, phase_ofs=0x40 -> first sample 0x41 (acc already stepped), wrap every 256 samples.
//  - ftw=0x8000, mode=square -> outputs alternate 255,0,...; wrap on every 0 sample.
//  - ftw_load with en same cycle (old 256 -> new 512) -> that step +1 index, subsequent +2.
//  - en toggled 1-0-1 -> exactly 2 dds_valid pulses, 3 cycles after each en; dds_out held between.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS phase generator.
// Waveform select codes, LUT geometry, the per-stage pipeline record and
// the two small sample-mapping helpers used by the output stage.
package dds_pkg;

   typedef enum logic [1:0] {
      DDS_SINE = 2'b00,
      DDS_SAW  = 2'b01,
      DDS_SQR  = 2'b10,
      DDS_TRI  = 2'b11
   } dds_mode_e;

   localparam int         LUT_DEPTH = 64;
   localparam logic [7:0] MIDSCALE  = 8'd128;

   // Pipeline record carried from S1 into S2. The quadrant is p[7:6] and is
   // not stored separately.
   typedef struct packed {
      logic [7:0] p;
      dds_mode_e  mode;
      logic       wrap;
      logic       valid;
   } dds_stage_t;

   // Rebuild a full-wave offset-binary sine sample from a quarter-wave magnitude.
   function automatic logic [7:0] sine_fold(input logic [6:0] mag, input logic neg_half);
      logic [7:0] mag8;
      mag8 = {1'b0, mag};
      return neg_half ? (MIDSCALE - mag8) : (MIDSCALE + mag8);
   endfunction

   // Triangle: rising 0..254 on even codes over the first half, falling 255..1
   // on odd codes over the second half.
   function automatic logic [7:0] tri_map(input logic [7:0] p);
      return p[7] ? ({~p[6:0], 1'b0} | 8'd1) : {p[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/dds_sine_qlut.sv
// Quarter-wave sine ROM: 64 entries of round(127*sin(pi/2*(i+0.5)/64)).
// The half-LSB phase offset keeps the table symmetric so that mirroring the
// address with ~addr gives an exact quarter-wave reflection.
module dds_sine_qlut
   import dds_pkg::*;
#(
   parameter int AW = $clog2(LUT_DEPTH),
   parameter int DW = 7
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   logic [DW-1:0] data_d;
   logic [DW-1:0] data_q;

   // ROM contents as a case table
   always_comb begin
      data_d = '0;
      case (addr)
         6'd0:  data_d = 7'd2;
         6'd1:  data_d = 7'd5;
         6'd2:  data_d = 7'd8;
         6'd3:  data_d = 7'd11;
         6'd4:  data_d = 7'd14;
         6'd5:  data_d = 7'd17;
         6'd6:  data_d = 7'd20;
         6'd7:  data_d = 7'd23;
         6'd8:  data_d = 7'd26;
         6'd9:  data_d = 7'd29;
         6'd10: data_d = 7'd32;
         6'd11: data_d = 7'd35;
         6'd12: data_d = 7'd38;
         6'd13: data_d = 7'd41;
         6'd14: data_d = 7'd44;
         6'd15: data_d = 7'd47;
         6'd16: data_d = 7'd50;
         6'd17: data_d = 7'd53;
         6'd18: data_d = 7'd56;
         6'd19: data_d = 7'd58;
         6'd20: data_d = 7'd61;
         6'd21: data_d = 7'd64;
         6'd22: data_d = 7'd67;
         6'd23: data_d = 7'd69;
         6'd24: data_d = 7'd72;
         6'd25: data_d = 7'd74;
         6'd26: data_d = 7'd77;
         6'd27: data_d = 7'd79;
         6'd28: data_d = 7'd82;
         6'd29: data_d = 7'd84;
         6'd30: data_d = 7'd86;
         6'd31: data_d = 7'd89;
         6'd32: data_d = 7'd91;
         6'd33: data_d = 7'd93;
         6'd34: data_d = 7'd95;
         6'd35: data_d = 7'd97;
         6'd36: data_d = 7'd99;
         6'd37: data_d = 7'd101;
         6'd38: data_d = 7'd103;
         6'd39: data_d = 7'd105;
         6'd40: data_d = 7'd106;
         6'd41: data_d = 7'd108;
         6'd42: data_d = 7'd110;
         6'd43: data_d = 7'd111;
         6'd44: data_d = 7'd113;
         6'd45: data_d = 7'd114;
         6'd46: data_d = 7'd115;
         6'd47: data_d = 7'd117;
         6'd48: data_d = 7'd118;
         6'd49: data_d = 7'd119;
         6'd50: data_d = 7'd120;
         6'd51: data_d = 7'd121;
         6'd52: data_d = 7'd122;
         6'd53: data_d = 7'd123;
         6'd54: data_d = 7'd124;
         6'd55: data_d = 7'd124;
         6'd56: data_d = 7'd125;
         6'd57: data_d = 7'd125;
         6'd58: data_d = 7'd126;
         6'd59: data_d = 7'd126;
         6'd60: data_d = 7'd127;
         6'd61: data_d = 7'd127;
         6'd62: data_d = 7'd127;
         6'd63: data_d = 7'd127;
         default: data_d = '0;
      endcase
   end

   // Registered read; contents only matter when the matching valid bit is set,
   // so the ROM register carries no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase generator: FTW register, phase accumulator and a three-register
// sample pipeline (phase fold, LUT read, waveform select) with valid and wrap
// flags travelling alongside each sample.
// A step taken on the clock edge that samples en produces its sample on the
// third following edge; dds_out holds its last value when dds_valid is low.
module dds_phase_gen
   import dds_pkg::*;
#(
   parameter int ACC_W  = 16,
   parameter int LUT_AW = 6,
   parameter int OUT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ftw_load,
   input  logic [ACC_W-1:0] ftw_in,
   input  logic [7:0]       phase_ofs,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] dds_out,
   output logic             dds_valid,
   output logic             wrap
);

   // S0: tuning word and accumulator
   logic [ACC_W-1:0] ftw_d, ftw_q;
   logic [ACC_W-1:0] acc_d, acc_q;
   logic             carry_d, carry_q;
   logic             s0_valid_d, s0_valid_q;

   // S1: folded phase and LUT address
   logic [7:0]        phase_sum;
   dds_stage_t        s1_stage_d, s1_stage_q;
   logic [LUT_AW-1:0] s1_idx_d, s1_idx_q;

   // S2: LUT output (registered inside the ROM) and stage copy
   dds_stage_t s2_stage_d, s2_stage_q;
   logic [6:0] lut_data;

   // S3: output registers
   logic [7:0]       sample;
   logic [OUT_W-1:0] dds_out_d, dds_out_q;
   logic             dds_valid_d, dds_valid_q;
   logic             wrap_d, wrap_q;

   // Accumulator step; a same-cycle FTW load only affects later steps because
   // the adder always reads the registered ftw_q.
   always_comb begin
      ftw_d      = ftw_load ? ftw_in : ftw_q;
      acc_d      = acc_q;
      carry_d    = 1'b0;
      s0_valid_d = en;
      if (en) begin
         {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, ftw_q};
      end
   end

   // Phase offset, quadrant fold and capture of the per-sample controls
   always_comb begin
      phase_sum        = acc_q[ACC_W-1 -: 8] + phase_ofs;
      s1_stage_d       = '0;
      s1_stage_d.p     = phase_sum;
      s1_stage_d.mode  = dds_mode_e'(mode);
      s1_stage_d.wrap  = carry_q;
      s1_stage_d.valid = s0_valid_q;
      // Odd quadrants run the quarter-wave table backwards
      s1_idx_d = phase_sum[6] ? ~phase_sum[LUT_AW-1:0] : phase_sum[LUT_AW-1:0];
   end

   dds_sine_qlut #(
      .AW (LUT_AW),
      .DW (7)
   ) u_qlut (
      .clk  (clk),
      .addr (s1_idx_q),
      .data (lut_data)
   );

   // Stage copy that lines the controls up with the registered LUT data
   always_comb begin
      s2_stage_d = s1_stage_q;
   end

   // Waveform select, output hold and wrap gating
   always_comb begin
      sample = '0;
      case (s2_stage_q.mode)
         DDS_SINE: sample = sine_fold(lut_data, s2_stage_q.p[7]);
         DDS_SAW:  sample = s2_stage_q.p;
         DDS_SQR:  sample = {8{s2_stage_q.p[7]}};
         DDS_TRI:  sample = tri_map(s2_stage_q.p);
         default:  sample = '0;
      endcase
      dds_out_d   = s2_stage_q.valid ? OUT_W'(sample) : dds_out_q;
      dds_valid_d = s2_stage_q.valid;
      wrap_d      = s2_stage_q.valid & s2_stage_q.wrap;
   end

   // All pipeline state; reset discards every in-flight sample
   always_ff @(posedge clk) begin
      if (rst) begin
         ftw_q       <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         s0_valid_q  <= 1'b0;
         s1_stage_q  <= '0;
         s1_idx_q    <= '0;
         s2_stage_q  <= '0;
         dds_out_q   <= '0;
         dds_valid_q <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         ftw_q       <= ftw_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         s0_valid_q  <= s0_valid_d;
         s1_stage_q  <= s1_stage_d;
         s1_idx_q    <= s1_idx_d;
         s2_stage_q  <= s2_stage_d;
         dds_out_q   <= dds_out_d;
         dds_valid_q <= dds_valid_d;
         wrap_q      <= wrap_d;
      end
   end

   assign dds_out   = dds_out_q;
   assign dds_valid = dds_valid_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen. Inputs change just after a falling edge
// and outputs are read on the next falling edge; obs_*[c] holds what was seen
// at the end of drive cycle c. A step requested in cycle c shows at obs_*[c+3].
module tb_dds_phase_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        ftw_load;
   logic [15:0] ftw_in;
   logic [7:0]  phase_ofs;
   logic [1:0]  mode;
   logic [7:0]  dds_out;
   logic        dds_valid;
   logic        wrap;

   int n_cmp  = 0;
   int n_fail = 0;

   logic       obs_v [600];
   logic [7:0] obs_o [600];
   logic       obs_w [600];

   dds_phase_gen #(
      .ACC_W  (16),
      .LUT_AW (6),
      .OUT_W  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .ftw_load  (ftw_load),
      .ftw_in    (ftw_in),
      .phase_ofs (phase_ofs),
      .mode      (mode),
      .dds_out   (dds_out),
      .dds_valid (dds_valid),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      rst = 1'b1; en = 1'b0; ftw_load = 1'b0; ftw_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drive_cycle(input logic en_v, input logic ld_v, input logic [15:0] ftw_v,
                              input int slot);
      en = en_v; ftw_load = ld_v; ftw_in = ftw_v;
      @(negedge clk);
      obs_v[slot] = dds_valid;
      obs_o[slot] = dds_out;
      obs_w[slot] = wrap;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; ftw_load = 1'b0; ftw_in = '0;
      mode = 2'd0; phase_ofs = 8'd0;
      repeat (2) @(negedge clk);
      n_cmp++; if (dds_out !== 8'd0) begin n_fail++; $display("FAIL reset_out: got %0d expected 0", dds_out); end
      n_cmp++; if (dds_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", dds_valid); end
      n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) drive_cycle(1'b0, 1'b0, 16'd0, c);
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if (obs_v[c] !== 1'b0) begin n_fail++; $display("FAIL idle_valid[%0d]: got %0b expected 0", c, obs_v[c]); end
      end
   endtask

   task automatic test_sine();
      apply_reset();
      mode = 2'd0; phase_ofs = 8'd0;
      drive_cycle(1'b0, 1'b1, 16'd256, 0);
      for (int c = 1; c <= 262; c++) drive_cycle(1'b1, 1'b0, 16'd0, c);
      n_cmp++; if (obs_v[3] !== 1'b0) begin n_fail++; $display("FAIL sine_latency: valid got %0b expected 0", obs_v[3]); end
      n_cmp++; if (obs_v[4] !== 1'b1) begin n_fail++; $display("FAIL sine_first_valid: got %0b expected 1", obs_v[4]); end
      n_cmp++; if (obs_o[4] !== 8'd133) begin n_fail++; $display("FAIL sine_ph1: got %0d expected 133", obs_o[4]); end
      n_cmp++; if (obs_o[67] !== 8'd255) begin n_fail++; $display("FAIL sine_ph64: got %0d expected 255", obs_o[67]); end
      n_cmp++; if (obs_o[131] !== 8'd126) begin n_fail++; $display("FAIL sine_ph128: got %0d expected 126", obs_o[131]); end
      n_cmp++; if (obs_o[195] !== 8'd1) begin n_fail++; $display("FAIL sine_ph192: got %0d expected 1", obs_o[195]); end
      n_cmp++; if (obs_o[259] !== 8'd130) begin n_fail++; $display("FAIL sine_ph0: got %0d expected 130", obs_o[259]); end
      n_cmp++; if (obs_o[260] !== 8'd133) begin n_fail++; $display("FAIL sine_period: got %0d expected 133", obs_o[260]); end
      n_cmp++; if (obs_w[258] !== 1'b0) begin n_fail++; $display("FAIL sine_wrap_early: got %0b expected 0", obs_w[258]); end
      n_cmp++; if (obs_w[259] !== 1'b1) begin n_fail++; $display("FAIL sine_wrap: got %0b expected 1", obs_w[259]); end
   endtask

   task automatic test_saw_offset();
      int wraps;
      apply_reset();
      mode = 2'd1; phase_ofs = 8'h40;
      drive_cycle(1'b0, 1'b1, 16'd256, 0);
      for (int c = 1; c <= 520; c++) drive_cycle(1'b1, 1'b0, 16'd0, c);
      wraps = 0;
      for (int i = 4; i <= 520; i++) if (obs_w[i] === 1'b1) wraps++;
      n_cmp++; if (obs_o[4] !== 8'h41) begin n_fail++; $display("FAIL saw_first: got %0h expected 41", obs_o[4]); end
      n_cmp++; if (obs_o[259] !== 8'h40) begin n_fail++; $display("FAIL saw_at_wrap: got %0h expected 40", obs_o[259]); end
      n_cmp++; if (obs_w[259] !== 1'b1) begin n_fail++; $display("FAIL saw_wrap1: got %0b expected 1", obs_w[259]); end
      n_cmp++; if (obs_w[515] !== 1'b1) begin n_fail++; $display("FAIL saw_wrap2: got %0b expected 1", obs_w[515]); end
      n_cmp++; if (wraps !== 2) begin n_fail++; $display("FAIL saw_wrap_count: got %0d expected 2", wraps); end
   endtask

   task automatic test_square();
      apply_reset();
      mode = 2'd2; phase_ofs = 8'd0;
      drive_cycle(1'b0, 1'b1, 16'h8000, 0);
      for (int c = 1; c <= 12; c++) drive_cycle(1'b1, 1'b0, 16'd0, c);
      for (int j = 0; j < 8; j++) begin
         n_cmp++;
         if (obs_o[4+j] !== ((j % 2 == 0) ? 8'd255 : 8'd0)) begin
            n_fail++; $display("FAIL square_out[%0d]: got %0d expected %0d", j, obs_o[4+j], (j % 2 == 0) ? 255 : 0);
         end
         n_cmp++;
         if (obs_w[4+j] !== ((j % 2) == 1)) begin
            n_fail++; $display("FAIL square_wrap[%0d]: got %0b expected %0b", j, obs_w[4+j], (j % 2) == 1);
         end
      end
   endtask

   task automatic test_ftw_change();
      logic [7:0] exp_o [7];
      exp_o = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd10};
      apply_reset();
      mode = 2'd1; phase_ofs = 8'd0;
      drive_cycle(1'b0, 1'b1, 16'd256, 0);
      for (int c = 1; c <= 3; c++) drive_cycle(1'b1, 1'b0, 16'd0, c);
      drive_cycle(1'b1, 1'b1, 16'd512, 4);
      for (int c = 5; c <= 7; c++) drive_cycle(1'b1, 1'b0, 16'd0, c);
      for (int c = 8; c <= 10; c++) drive_cycle(1'b0, 1'b0, 16'd0, c);
      for (int i = 0; i < 7; i++) begin
         n_cmp++;
         if (obs_o[4+i] !== exp_o[i]) begin
            n_fail++; $display("FAIL ftw_step[%0d]: got %0d expected %0d", i, obs_o[4+i], exp_o[i]);
         end
      end
   endtask

   task automatic test_en_toggle();
      int pulses;
      apply_reset();
      mode = 2'd1; phase_ofs = 8'd0;
      drive_cycle(1'b0, 1'b1, 16'd256, 0);
      drive_cycle(1'b1, 1'b0, 16'd0, 1);
      drive_cycle(1'b0, 1'b0, 16'd0, 2);
      drive_cycle(1'b1, 1'b0, 16'd0, 3);
      for (int c = 4; c <= 11; c++) drive_cycle(1'b0, 1'b0, 16'd0, c);
      pulses = 0;
      for (int i = 0; i <= 11; i++) begin
         if (obs_v[i] === 1'b1) pulses++;
         n_cmp++;
         if (obs_v[i] !== (i == 4 || i == 6)) begin
            n_fail++; $display("FAIL toggle_valid[%0d]: got %0b expected %0b", i, obs_v[i], (i == 4 || i == 6));
         end
      end
      n_cmp++; if (pulses !== 2) begin n_fail++; $display("FAIL toggle_pulses: got %0d expected 2", pulses); end
      n_cmp++; if (obs_o[4] !== 8'd1) begin n_fail++; $display("FAIL toggle_first: got %0d expected 1", obs_o[4]); end
      n_cmp++; if (obs_o[5] !== 8'd1) begin n_fail++; $display("FAIL toggle_hold: got %0d expected 1", obs_o[5]); end
      n_cmp++; if (obs_o[6] !== 8'd2) begin n_fail++; $display("FAIL toggle_second: got %0d expected 2", obs_o[6]); end
      n_cmp++; if (obs_o[11] !== 8'd2) begin n_fail++; $display("FAIL toggle_hold_end: got %0d expected 2", obs_o[11]); end
   endtask

   // ftw stays 0 after reset, so the phase index is just phase_ofs
   task automatic test_phase_map();
      logic [1:0] t_mode [16];
      logic [7:0] t_ofs  [16];
      logic [7:0] t_exp  [16];
      t_mode = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0,
                 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1};
      t_ofs  = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hC0, 8'h40, 8'h20,
                 8'hFF, 8'h01, 8'hA0, 8'h3F, 8'h9C, 8'h7F, 8'h80, 8'h10};
      t_exp  = '{8'd0, 8'd2, 8'd254, 8'd255, 8'd1, 8'd127, 8'd128, 8'd219,
                 8'd126, 8'd133, 8'd37, 8'd255, 8'd156, 8'd0, 8'd255, 8'd16};
      apply_reset();
      mode = 2'd3; phase_ofs = 8'd0;
      for (int c = 0; c <= 19; c++) begin
         if (c >= 1 && c <= 16) begin
            mode = t_mode[c-1]; phase_ofs = t_ofs[c-1];
         end
         drive_cycle(1'b1, 1'b0, 16'd0, c);
      end
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (obs_o[k+3] !== t_exp[k]) begin
            n_fail++; $display("FAIL map[%0d] mode %0d ofs %0h: got %0d expected %0d", k, t_mode[k], t_ofs[k], obs_o[k+3], t_exp[k]);
         end
         n_cmp++;
         if (obs_v[k+3] !== 1'b1) begin n_fail++; $display("FAIL map_valid[%0d]: got %0b expected 1", k, obs_v[k+3]); end
         n_cmp++;
         if (obs_w[k+3] !== 1'b0) begin n_fail++; $display("FAIL map_wrap[%0d]: got %0b expected 0", k, obs_w[k+3]); end
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      mode = 2'd1; phase_ofs = 8'd0;
      drive_cycle(1'b0, 1'b1, 16'd256, 0);
      for (int c = 1; c <= 20; c++) drive_cycle(1'b1, 1'b0, 16'd0, c);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (dds_out !== 8'd0) begin n_fail++; $display("FAIL midrst_out: got %0d expected 0", dds_out); end
      n_cmp++; if (dds_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b expected 0", dds_valid); end
      n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL midrst_wrap: got %0b expected 0", wrap); end
      rst = 1'b0;
      drive_cycle(1'b0, 1'b1, 16'd256, 0);
      for (int c = 1; c <= 6; c++) drive_cycle(1'b1, 1'b0, 16'd0, c);
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if (obs_v[c] !== 1'b0) begin n_fail++; $display("FAIL midrst_flush[%0d]: got %0b expected 0", c, obs_v[c]); end
      end
      n_cmp++; if (obs_v[4] !== 1'b1) begin n_fail++; $display("FAIL midrst_restart_valid: got %0b expected 1", obs_v[4]); end
      n_cmp++; if (obs_o[4] !== 8'd1) begin n_fail++; $display("FAIL midrst_restart_out: got %0d expected 1", obs_o[4]); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; ftw_load = 1'b0; ftw_in = '0;
      phase_ofs = 8'd0; mode = 2'd0;
      test_reset();
      test_sine();
      test_saw_offset();
      test_square();
      test_ftw_change();
      test_en_toggle();
      test_phase_map();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
